// File: rtl/wide_alu_sequencer.sv
// wide_alu_sequencer
// Splits 16-bit ADD / shift-left / XOR requests into low-byte and high-byte
// micro-ops on the neighbouring 8-bit ALU, chains the carry between halves
// and reassembles the 16-bit result.
//
// Ports:
//   CLK, RESET        clock, asynchronous active-high reset
//   START, OP_SEL     request strobe and opcode (00 ADD, 01 SHL, 10 XOR, 11 illegal)
//   A16, B16, SHAMT   operands and shift count, latched on an accepted START
//   ALU_OP/A/B/SC_IN  drive the ALU
//   ALU_OUT/SC_OUT    sampled from the ALU
//   RESULT            16-bit result, changes only when DONE is entered
//   BUSY, DONE, ERR   status: in LOW/HIGH, result-valid pulse, illegal op
//
// state  | meaning
// IDLE   | waiting for START
// LOW    | ALU works on the low byte, carry captured
// HIGH   | ALU works on the high byte with the captured carry
// DONE   | RESULT valid for one cycle; START here is accepted
module wide_alu_sequencer #(
    parameter int SHAMT_W = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic [1:0]         OP_SEL,
    input  logic [15:0]        A16,
    input  logic [15:0]        B16,
    input  logic [SHAMT_W-1:0] SHAMT,
    output logic [3:0]         ALU_OP,
    output logic [7:0]         ALU_A,
    output logic [7:0]         ALU_B,
    output logic               ALU_SC_IN,
    input  logic [7:0]         ALU_OUT,
    input  logic               ALU_SC_OUT,
    output logic [15:0]        RESULT,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR
);

    localparam logic [3:0] K_ADDL = 4'h0;
    localparam logic [3:0] K_ADDU = 4'h1;
    localparam logic [3:0] K_LSAL = 4'h2;
    localparam logic [3:0] K_LSAU = 4'h3;
    localparam logic [3:0] K_XOR  = 4'h4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SHL = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [15:0]        a_q;        // operand A; doubles as the shift working value
    logic [15:0]        b_q;
    logic [1:0]         op_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               carry_q;
    logic [7:0]         lo_q;
    logic [15:0]        result_q;
    logic               err_q;
    logic               accept;

    assign accept = START && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            lo_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        a_q   <= A16;
                        b_q   <= B16;
                        op_q  <= OP_SEL;
                        cnt_q <= SHAMT;
                        err_q <= 1'b0;
                        if (OP_SEL == OP_ILL) begin
                            result_q <= '0;
                            err_q    <= 1'b1;
                            state    <= S_DONE;
                        end else if (OP_SEL == OP_SHL && SHAMT == '0) begin
                            result_q <= A16;
                            state    <= S_DONE;
                        end else begin
                            state <= S_LOW;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LOW: begin
                    lo_q    <= ALU_OUT;
                    // XOR leaves SC_OUT undefined, so it must not leak into HIGH
                    carry_q <= (op_q == OP_XOR) ? 1'b0 : ALU_SC_OUT;
                    state   <= S_HIGH;
                end
                S_HIGH: begin
                    if (op_q == OP_SHL) begin
                        // one bit per LOW/HIGH pass
                        a_q   <= {ALU_OUT, lo_q};
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == SHAMT_W'(1)) begin
                            result_q <= {ALU_OUT, lo_q};
                            state    <= S_DONE;
                        end else begin
                            state <= S_LOW;
                        end
                    end else begin
                        result_q <= {ALU_OUT, lo_q};
                        state    <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ALU_OP    = K_ADDL;
        ALU_A     = '0;
        ALU_B     = '0;
        ALU_SC_IN = 1'b0;
        case (state)
            S_LOW: begin
                case (op_q)
                    OP_ADD: begin ALU_OP = K_ADDL; ALU_A = a_q[7:0]; ALU_B = b_q[7:0]; end
                    OP_SHL: begin ALU_OP = K_LSAL; ALU_A = a_q[7:0]; end
                    OP_XOR: begin ALU_OP = K_XOR;  ALU_A = a_q[7:0]; ALU_B = b_q[7:0]; end
                    default: ALU_OP = K_ADDL;
                endcase
            end
            S_HIGH: begin
                ALU_SC_IN = carry_q;
                case (op_q)
                    OP_ADD: begin ALU_OP = K_ADDU; ALU_A = a_q[15:8]; ALU_B = b_q[15:8]; end
                    OP_SHL: begin ALU_OP = K_LSAU; ALU_A = a_q[15:8]; end
                    OP_XOR: begin ALU_OP = K_XOR;  ALU_A = a_q[15:8]; ALU_B = b_q[15:8]; end
                    default: ALU_OP = K_ADDL;
                endcase
            end
            default: ALU_OP = K_ADDL;
        endcase
    end

    assign RESULT = result_q;
    assign BUSY   = (state == S_LOW) || (state == S_HIGH);
    assign DONE   = (state == S_DONE);
    assign ERR    = err_q;

endmodule

// File: tb/tb_wide_alu_sequencer.sv
// Testbench for wide_alu_sequencer: an 8-bit ALU model sits beside the DUT,
// expected results are queued when a request is issued and compared against
// RESULT/ERR and the DONE cycle when DONE appears.
module tb_wide_alu_sequencer;

    localparam int SHAMT_W = 4;

    localparam logic [3:0] K_ADDL = 4'h0;
    localparam logic [3:0] K_ADDU = 4'h1;
    localparam logic [3:0] K_LSAL = 4'h2;
    localparam logic [3:0] K_LSAU = 4'h3;
    localparam logic [3:0] K_XOR  = 4'h4;

    logic               CLK = 1'b0;
    logic               RESET;
    logic               START;
    logic [1:0]         OP_SEL;
    logic [15:0]        A16, B16;
    logic [SHAMT_W-1:0] SHAMT;
    logic [3:0]         ALU_OP;
    logic [7:0]         ALU_A, ALU_B;
    logic               ALU_SC_IN;
    logic [7:0]         ALU_OUT;
    logic               ALU_SC_OUT;
    logic [15:0]        RESULT;
    logic               BUSY, DONE, ERR;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int          done_cyc;
        logic [15:0] res;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  sh;
        logic [15:0] res;
        logic        err;
        int          lat;
    } vec_t;
    vec_t vecs[12];

    wide_alu_sequencer #(.SHAMT_W(SHAMT_W)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .OP_SEL(OP_SEL),
        .A16(A16), .B16(B16), .SHAMT(SHAMT),
        .ALU_OP(ALU_OP), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_SC_IN(ALU_SC_IN),
        .ALU_OUT(ALU_OUT), .ALU_SC_OUT(ALU_SC_OUT),
        .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // 8-bit ALU model; XOR reports SC_OUT=1 as a stand-in for "undefined"
    always_comb begin
        ALU_OUT    = '0;
        ALU_SC_OUT = 1'b0;
        case (ALU_OP)
            K_ADDL: {ALU_SC_OUT, ALU_OUT} = 9'(ALU_A) + 9'(ALU_B) + 9'(ALU_SC_IN);
            K_ADDU: ALU_OUT = ALU_A + ALU_B + 8'(ALU_SC_IN);
            K_LSAL: begin ALU_OUT = {ALU_A[6:0], 1'b0};      ALU_SC_OUT = ALU_A[7]; end
            K_LSAU: begin ALU_OUT = {ALU_A[6:0], ALU_SC_IN}; ALU_SC_OUT = ALU_A[7]; end
            K_XOR:  begin ALU_OUT = ALU_A ^ ALU_B;           ALU_SC_OUT = 1'b1; end
            default: ALU_OUT = '0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // caller is positioned just after a rising edge
    task automatic do_start(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] sh, input logic [15:0] res, input logic err,
                            input int lat);
        exp_t e;
        OP_SEL = op; A16 = a; B16 = b; SHAMT = sh; START = 1'b1;
        e.done_cyc = cyc + lat;
        e.res = res;
        e.err = err;
        sb.push_back(e);
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge CLK);
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RESET && DONE) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: DONE=1 expected 0 at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("result", 32'(RESULT), 32'(e.res));
                chk("err", 32'(ERR), 32'(e.err));
                chk("done_cycle", cyc, e.done_cyc);
            end
        end
    end

    logic [1:0]  rop;
    logic [15:0] ra, rb, rexp;
    logic [3:0]  rsh;
    int          rlat;
    int          busy_cnt;

    initial begin
        vecs[0]  = '{2'b00, 16'h12FF, 16'h0001, 4'd0,  16'h1300, 1'b0, 3};
        vecs[1]  = '{2'b10, 16'hA5A5, 16'h0FF0, 4'd0,  16'hAA55, 1'b0, 3};
        vecs[2]  = '{2'b01, 16'h8181, 16'h0000, 4'd1,  16'h0302, 1'b0, 3};
        vecs[3]  = '{2'b01, 16'h1234, 16'h0000, 4'd4,  16'h2340, 1'b0, 9};
        vecs[4]  = '{2'b01, 16'h1234, 16'hFFFF, 4'd0,  16'h1234, 1'b0, 1};
        vecs[5]  = '{2'b11, 16'hFFFF, 16'hFFFF, 4'd0,  16'h0000, 1'b1, 1};
        vecs[6]  = '{2'b00, 16'hFFFF, 16'h0001, 4'd0,  16'h0000, 1'b0, 3};
        vecs[7]  = '{2'b01, 16'hFFFF, 16'h0000, 4'd15, 16'h8000, 1'b0, 31};
        vecs[8]  = '{2'b00, 16'h00FF, 16'h00FF, 4'd0,  16'h01FE, 1'b0, 3};
        vecs[9]  = '{2'b10, 16'hFFFF, 16'hFFFF, 4'd0,  16'h0000, 1'b0, 3};
        vecs[10] = '{2'b00, 16'h8000, 16'h8000, 4'd0,  16'h0000, 1'b0, 3};
        vecs[11] = '{2'b01, 16'h0001, 16'h1234, 4'd8,  16'h0100, 1'b0, 17};

        RESET = 1'b1; START = 1'b0; OP_SEL = '0; A16 = '0; B16 = '0; SHAMT = '0;
        #12;
        chk("rst_result", 32'(RESULT), 32'h0);
        chk("rst_done", 32'(DONE), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_err", 32'(ERR), 32'h0);
        chk("rst_alu_op", 32'(ALU_OP), 32'(K_ADDL));
        chk("rst_alu_a", 32'(ALU_A), 32'h0);
        chk("rst_alu_b", 32'(ALU_B), 32'h0);
        chk("rst_sc_in", 32'(ALU_SC_IN), 32'h0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        // ADD carry chain, micro-op by micro-op
        do_start(2'b00, 16'h12FF, 16'h0001, 4'd0, 16'h1300, 1'b0, 3);
        chk("add_low_op", 32'(ALU_OP), 32'(K_ADDL));
        chk("add_low_a", 32'(ALU_A), 32'hFF);
        chk("add_low_b", 32'(ALU_B), 32'h01);
        chk("add_low_sc_out", 32'(ALU_SC_OUT), 32'h1);
        chk("add_low_busy", 32'(BUSY), 32'h1);
        chk("add_low_result_held", 32'(RESULT), 32'h0);
        @(posedge CLK); #1;
        chk("add_high_op", 32'(ALU_OP), 32'(K_ADDU));
        chk("add_high_a", 32'(ALU_A), 32'h12);
        chk("add_high_b", 32'(ALU_B), 32'h00);
        chk("add_high_sc_in", 32'(ALU_SC_IN), 32'h1);
        chk("add_high_result_held", 32'(RESULT), 32'h0);
        wait_idle();

        // XOR must not pass the ALU's undefined SC_OUT into HIGH
        do_start(2'b10, 16'hA5A5, 16'h0FF0, 4'd0, 16'hAA55, 1'b0, 3);
        @(posedge CLK); #1;
        chk("xor_high_op", 32'(ALU_OP), 32'(K_XOR));
        chk("xor_high_a", 32'(ALU_A), 32'hA5);
        chk("xor_high_b", 32'(ALU_B), 32'h0F);
        chk("xor_high_sc_in", 32'(ALU_SC_IN), 32'h0);
        wait_idle();

        for (int i = 0; i < 12; i++) begin
            do_start(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh,
                     vecs[i].res, vecs[i].err, vecs[i].lat);
            wait_idle();
        end

        // SHL by 4: BUSY for exactly 8 cycles
        do_start(2'b01, 16'h1234, 16'h0000, 4'd4, 16'h2340, 1'b0, 9);
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (BUSY) busy_cnt++;
        end
        chk("shl4_busy_cycles", busy_cnt, 8);
        @(posedge CLK); #1;
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 2));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rsh = 4'($urandom_range(0, 15));
            case (rop)
                2'b00:   begin rexp = ra + rb; rlat = 3; end
                2'b01:   begin rexp = ra << rsh; rlat = (rsh == 0) ? 1 : 1 + 2 * int'(rsh); end
                default: begin rexp = ra ^ rb; rlat = 3; end
            endcase
            do_start(rop, ra, rb, rsh, rexp, 1'b0, rlat);
            wait_idle();
        end

        // START while BUSY, in both LOW and HIGH, is ignored
        do_start(2'b00, 16'h12FF, 16'h0001, 4'd0, 16'h1300, 1'b0, 3);
        OP_SEL = 2'b10; A16 = 16'hFFFF; B16 = 16'h0000; SHAMT = 4'd3; START = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
        START = 1'b0;
        wait_idle();

        // back-to-back: START in the DONE cycle
        do_start(2'b00, 16'h00FF, 16'h0001, 4'd0, 16'h0100, 1'b0, 3);
        repeat (2) begin @(posedge CLK); #1; end
        chk("b2b_done_cycle", 32'(DONE), 32'h1);
        do_start(2'b10, 16'h1234, 16'hFFFF, 4'd0, 16'hEDCB, 1'b0, 3);
        chk("b2b_busy_next", 32'(BUSY), 32'h1);
        wait_idle();

        // illegal op followed immediately by a legal one (ERR cleared)
        do_start(2'b11, 16'h5555, 16'h5555, 4'd0, 16'h0000, 1'b1, 1);
        do_start(2'b00, 16'h0102, 16'h0304, 4'd0, 16'h0406, 1'b0, 3);
        wait_idle();

        // reset during HIGH of an ADD
        do_start(2'b00, 16'h4000, 16'h4000, 4'd0, 16'h8000, 1'b0, 3);
        @(posedge CLK); #1;
        chk("midrst_in_high", 32'(ALU_OP), 32'(K_ADDU));
        #3;
        RESET = 1'b1;
        sb.delete();
        #1;
        chk("midrst_result", 32'(RESULT), 32'h0);
        chk("midrst_done", 32'(DONE), 32'h0);
        chk("midrst_busy", 32'(BUSY), 32'h0);
        chk("midrst_err", 32'(ERR), 32'h0);
        chk("midrst_alu_op", 32'(ALU_OP), 32'(K_ADDL));
        chk("midrst_sc_in", 32'(ALU_SC_IN), 32'h0);
        #20;
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("midrst_no_done", 32'(DONE), 32'h0);
        end
        @(posedge CLK); #1;
        do_start(2'b00, 16'h0001, 16'h0001, 4'd0, 16'h0002, 1'b0, 3);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wide_alu_sequencer.md
Name: wide_alu_sequencer

Overview:
- Multi-cycle control stage directly upstream of the 8-bit combinational ALU.
- Accepts 16-bit ADD, SHL-by-N and XOR requests and splits each into low-byte/high-byte ALU micro-ops.
- Carries SC_OUT from the low half into SC_IN of the high half and reassembles the 16-bit result with a done pulse.
- The ALU is instantiated beside this block; this block drives all ALU inputs and samples the ALU outputs.

Parameters:
SHAMT_W, 4, width of shift-amount input; max shift = 2**SHAMT_W - 1

Ports:
CLK  input  1  single clock, all state updates on rising edge
RESET  input  1  asynchronous, active-high reset
START  input  1  request strobe; accepted only in IDLE or DONE
OP_SEL  input  2  00=ADD16, 01=SHL16, 10=XOR16, 11=illegal
A16  input  16  operand A, latched on accepted START
B16  input  16  operand B, latched on accepted START; ignored for SHL16
SHAMT  input  SHAMT_W  shift count for SHL16, latched on accepted START
ALU_OP  output  4  opcode to ALU; kADDL/kLSAL/kADDU/kLSAU/kXOR from package definitions
ALU_A  output  8  ALU INPUTA
ALU_B  output  8  ALU INPUTB
ALU_SC_IN  output  1  ALU SC_IN, driven from internal carry register
ALU_OUT  input  8  ALU OUT
ALU_SC_OUT  input  1  ALU SC_OUT
RESULT  output  16  assembled result, held stable until the next accepted START
BUSY  output  1  high in LOW and HIGH states
DONE  output  1  one-cycle pulse when RESULT is valid
ERR  output  1  high with DONE when the op was illegal; cleared on next accepted START

Behaviour:
- Reset (async, immediate): state=IDLE; RESULT=0, BUSY=0, DONE=0, ERR=0, carry reg=0, shift counter=0; ALU_OP=kADDL with ALU_A=ALU_B=0, ALU_SC_IN=0.
- States: IDLE, LOW, HIGH, DONE.
  - IDLE/DONE + START: latch A16, B16, SHAMT, OP_SEL into working regs; clear ERR.
  - Next state after START:
    - legal op with SHAMT!=0, or ADD16/XOR16 -> LOW.
    - SHL16 with SHAMT=0 -> DONE, RESULT=A16.
    - OP_SEL=11 -> DONE, RESULT=0, ERR=1.
  - DONE without START -> IDLE.
  - START while BUSY is ignored; working regs are unchanged.
- LOW: ALU driven with the low bytes.
  - ADD16: kADDL, A[7:0], B[7:0].
  - SHL16: kLSAL, W[7:0].
  - XOR16: kXOR, A[7:0], B[7:0].
  - End of cycle: capture ALU_OUT into result low byte; carry reg <= ALU_SC_OUT (forced 0 for XOR16, whose SC_OUT is undefined). Next state is HIGH.
- HIGH: ALU driven with the high bytes and ALU_SC_IN=carry reg.
  - ADD16: kADDU, A[15:8], B[15:8].
  - SHL16: kLSAU, W[15:8].
  - XOR16: kXOR, A[15:8], B[15:8].
  - End of cycle: capture ALU_OUT into result high byte.
  - SHL16: W <= new 16-bit value and counter decrements; counter >0 -> LOW, else -> DONE.
  - ADD16/XOR16: -> DONE.
- Latency from START cycle N:
  - DONE in cycle N+3 for ADD16/XOR16.
  - DONE in cycle N+1+2*SHAMT for SHL16 (N+1 when SHAMT=0).
  - DONE in cycle N+1 for illegal ops.
- Arithmetic: ADD16 is modulo 2^16; the final carry is discarded because the ALU's upper-half ops do not produce one. SHL16 bits shifted past bit 15 are lost; zeros enter at bit 0.
- RESULT updates only on DONE entry, never mid-operation.
- Back-to-back: START in the DONE cycle is accepted, giving zero idle gap.
- Reset mid-operation aborts immediately; no DONE is issued; RESULT returns to 0.

Test Plan:
- Reset values: assert RESET asynchronously mid-cycle -> RESULT=0, DONE=0, BUSY=0, ERR=0, ALU_OP=kADDL immediately.
- ADD16, A=0x12FF, B=0x0001 -> LOW cycle ALU_SC_OUT=1, HIGH cycle ALU_SC_IN=1, RESULT=0x1300, DONE at N+3.
- XOR16, A=0xA5A5, B=0x0FF0 -> RESULT=0xAA55 at N+3; ALU_SC_IN=0 in HIGH.
- SHL16, A=0x8181, SHAMT=1 -> RESULT=0x0302 at N+3. SHL16, A=0x1234, SHAMT=4 -> RESULT=0x2340, DONE at N+9, BUSY high for 8 cycles. SHAMT=0 -> RESULT=A at N+1.
- Handshake edge cases:
  - START pulsed while BUSY with different operands -> ignored; original result is returned.
  - START in the DONE cycle -> new op begins at the next cycle.
  - OP_SEL=11 -> DONE and ERR at N+1, RESULT=0.
- Reset mid-operation: RESET during the HIGH cycle of an ADD16 -> no DONE pulse, state IDLE; a new ADD16 0x0001+0x0001 afterwards returns 0x0002.
